rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one bus master slot between NREQ requesters.
//  Each i_ready cycle it decides the next master and announces it on o_grant one cycle
//  ahead; o_master follows on the next clock edge.
//  A hold limit bounds how long one master keeps the bus while others wait.
//  Per-requester wait counters flag starvation, so the fairness checks in the bench have a
//  direct RTL observable.
// PARAMETERS
//  NREQ        3   number of requesters, legal 2..4
//  MW          2   width of o_master, clog2(NREQ) rounded up, minimum 1
//  MAX_HOLD    4   max consecutive ready-cycles a master is retained while another req is pending, >=1
//  STARVE_LIM  12  wait count (ready-cycles) at which o_starve asserts, >= (NREQ-1)*MAX_HOLD
// PORTS
//  i_clk      in   1     clock, all state updates on posedge
//  i_rst      in   1     synchronous reset, active high
//  i_req      in   NREQ  request per requester, level sensitive
//  i_ready    in   1     bus ready; arbitration advances only on cycles with i_ready=1
//  o_grant    out  NREQ  one-hot grant = onehot(nxt_master), combinational from state + inputs
//  o_master   out  MW    current bus master index, registered
//  o_busy     out  1     1 when state=OWN
//  o_starve   out  1     1 when any wait_cnt[i] >= STARVE_LIM, registered
// BEHAVIOUR
//  Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
//  Reset: on a posedge with i_rst=1:
//   - o_master<=0, state<=PARK, hold_cnt<=0, all wait_cnt<=0, o_starve<=0.
//   - o_grant shows onehot(0) while i_rst is high.
//   - Reset mid-operation aborts any ownership; no grant is remembered.
//  Contract: if i_ready=1 in cycle t, then o_grant[i]=1 in cycle t <-> o_master==i in cycle t+1.
//  nxt_master (combinational):
//   - i_ready=0: nxt_master=o_master. All state, hold_cnt and wait_cnt hold.
//   - i_ready=1, keep case: if i_req[o_master]=1 and (no other req pending, or hold_cnt<MAX_HOLD-1),
//     then nxt_master=o_master.
//   - i_ready=1, otherwise: rotate. Scan o_master+1, +2, ... modulo NREQ (wrap NREQ-1 -> 0) and
//     take the first index with i_req=1.
//   - No request at all: park, nxt_master=o_master.
//   - Values >= NREQ are never produced; with NREQ=3, o_master=3 is unreachable.
//  On posedge with i_ready=1, o_master<=nxt_master.
//  FSM (updated only when i_ready=1):
//   - PARK->OWN: any i_req=1.
//   - OWN->PARK: i_req all 0.
//   - OWN->OWN: otherwise (this covers handover).
//  hold_cnt (width clog2(MAX_HOLD+1)):
//   - ready-cycle with master retained and another req pending: hold_cnt+1, saturating at MAX_HOLD.
//   - nxt_master != o_master, or no other req pending: reset to 0.
//  wait_cnt[i] (width clog2(STARVE_LIM+1), saturating):
//   - ready-cycle with i_req[i]=1 and nxt_master!=i: +1.
//   - nxt_master==i, or i_req[i]=0: cleared to 0.
//  Simultaneous events:
//   - If the current master drops req on the same cycle the hold limit is reached, rotation uses the
//     normal scan (no double skip).
//   - If the request of the master currently in o_master falls while i_ready=0, nothing changes
//     until the next ready cycle.
//  o_starve is registered from the updated wait_cnt, one cycle after the counter crosses STARVE_LIM.
//  Latency: grant-to-master is 1 cycle; an idle bus with a single new requester gets its grant in
//  the same ready cycle.
// TESTING
//  1. Reset: hold i_rst 2 cycles, req=0, ready=1 -> o_master=0, o_grant=001, o_busy=0, o_starve=0.
//  2. Single requester: req=010 with ready=1 -> o_grant=010 that cycle, o_master=1 next cycle,
//     o_busy=1; master stays 1 indefinitely.
//  3. Hold limit: req=111 from master 0, ready=1 continuously -> master sequence 0,0,0,0,1,1,1,1,2,...;
//     wrap 2->0 is checked; o_starve stays 0.
//  4. Ready gating: req=011, ready toggles 1,0,0,1 -> o_master and counters change only after ready
//     cycles; the grant-implies-next-master contract holds on every ready cycle.
//  5. Master drops req: master=1 with req changing 011->001 on a ready cycle -> o_grant=001,
//     o_master=0 next cycle, hold_cnt=0.
//  6. Starvation/reset: force STARVE_LIM=2, MAX_HOLD=4, req=011 -> o_starve=1 after wait_cnt[1]
//     reaches 2; asserting i_rst mid-burst -> all counters 0 and o_master=0 on the next cycle.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with a hold limit and per-requester starvation counters.
// o_grant announces the next master combinationally; o_master follows on the next ready edge.

module rr_wait_cnt #(
  parameter int LIM = 12,
  parameter int W   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_adv,
  input  logic i_req,
  input  logic i_win,
  output logic o_hit
);
  logic [W-1:0] cnt_q, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    if (i_adv) begin
      if (!i_req || i_win)         cnt_nxt = '0;
      else if (cnt_q != W'(LIM))   cnt_nxt = cnt_q + 1'b1;
    end
  end

  // Starvation flag is taken from the value being written this edge.
  assign o_hit = (cnt_nxt >= W'(LIM));

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_nxt;
  end
endmodule

module rr_bus_arbiter #(
  parameter int NREQ       = 3,
  parameter int MW         = 2,
  parameter int MAX_HOLD   = 4,
  parameter int STARVE_LIM = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_ready,
  output logic [NREQ-1:0] o_grant,
  output logic [MW-1:0]   o_master,
  output logic            o_busy,
  output logic            o_starve
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic {PARK, OWN} state_t;

  state_t          state_q;
  logic [MW-1:0]   master_q, nxt_master, rot_master;
  logic [HW-1:0]   hold_q, hold_nxt;
  logic [NREQ-1:0] mast_oh, hit;
  logic            cur_req, other_pend, keep, found;

  assign mast_oh    = NREQ'(1) << master_q;
  assign cur_req    = |(i_req & mast_oh);
  assign other_pend = |(i_req & ~mast_oh);
  assign keep       = cur_req && (!other_pend || hold_q < HW'(MAX_HOLD - 1));

  // Scan master+1, master+2, ... wrapping at NREQ; the current master is never rescanned.
  always_comb begin
    logic [MW:0] s;
    rot_master = master_q;
    found      = 1'b0;
    for (int k = 1; k < NREQ; k++) begin
      s = {1'b0, master_q} + (MW+1)'(k);
      if (s >= (MW+1)'(NREQ)) s = s - (MW+1)'(NREQ);
      if (!found && |(i_req & (NREQ'(1) << s))) begin
        found      = 1'b1;
        rot_master = s[MW-1:0];
      end
    end
  end

  always_comb begin
    nxt_master = master_q;
    if (i_ready && !keep && found) nxt_master = rot_master;
  end

  always_comb begin
    hold_nxt = '0;
    if (nxt_master == master_q && other_pend)
      hold_nxt = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
  end

  assign o_grant  = i_rst ? NREQ'(1) : (NREQ'(1) << nxt_master);
  assign o_master = master_q;
  assign o_busy   = (state_q == OWN);

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_wait
      rr_wait_cnt #(.LIM(STARVE_LIM), .W(CW)) u_wait (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (i_ready),
        .i_req (i_req[g]),
        .i_win (nxt_master == MW'(g)),
        .o_hit (hit[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= PARK;
      master_q <= '0;
      hold_q   <= '0;
      o_starve <= 1'b0;
    end else begin
      o_starve <= |hit;
      if (i_ready) begin
        master_q <= nxt_master;
        hold_q   <= hold_nxt;
        case (state_q)
          PARK:    state_q <= (|i_req) ? OWN : PARK;
          OWN:     state_q <= (|i_req) ? OWN : PARK;
          default: state_q <= PARK;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor pops and compares each cycle.

module tb_rr_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rdy_a = 1'b1, rst_b = 1'b1, rdy_b = 1'b1;
  logic [2:0] req_a = '0, req_b = '0;
  logic [2:0] grant_a, grant_b;
  logic [1:0] master_a, master_b;
  logic       busy_a, busy_b, starve_a, starve_b;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.NREQ(3), .MW(2), .MAX_HOLD(4), .STARVE_LIM(12)) u_a (
    .i_clk(clk), .i_rst(rst_a), .i_req(req_a), .i_ready(rdy_a),
    .o_grant(grant_a), .o_master(master_a), .o_busy(busy_a), .o_starve(starve_a)
  );

  rr_bus_arbiter #(.NREQ(3), .MW(2), .MAX_HOLD(4), .STARVE_LIM(2)) u_b (
    .i_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_ready(rdy_b),
    .o_grant(grant_b), .o_master(master_b), .o_busy(busy_b), .o_starve(starve_b)
  );

  typedef struct {
    bit         sel;
    logic [2:0] g;
    logic [1:0] m;
    logic       b;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge; grant is expected for this cycle,
  // master/busy/starve after the following rising edge.
  task automatic drv(input bit sel, input logic rst, input logic [2:0] req, input logic rdy,
                     input logic [2:0] eg, input logic [1:0] em, input logic eb,
                     input logic es, input string nm);
    exp_t e;
    @(negedge clk); #1;
    if (sel) begin rst_b = rst; req_b = req; rdy_b = rdy; end
    else     begin rst_a = rst; req_a = req; rdy_a = rdy; end
    e.sel = sel; e.g = eg; e.m = em; e.b = eb; e.s = es; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    exp_t       e;
    logic [2:0] gs;
    forever begin
      @(negedge clk); #3;
      if (q.size() > 0) begin
        e  = q.pop_front();
        gs = e.sel ? grant_b : grant_a;
        @(posedge clk); #1;
        chk({e.nm, " grant"},  int'(gs), int'(e.g));
        chk({e.nm, " master"}, int'(e.sel ? master_b : master_a), int'(e.m));
        chk({e.nm, " busy"},   int'(e.sel ? busy_b : busy_a),     int'(e.b));
        chk({e.nm, " starve"}, int'(e.sel ? starve_b : starve_a), int'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (2) drv(0, 1, 3'b000, 1, 3'b001, 0, 0, 0, "reset");
    // single requester: same-cycle grant, then retained
    repeat (4) drv(0, 0, 3'b010, 1, 3'b010, 1, 1, 0, "single");
    drv(0, 1, 3'b111, 1, 3'b001, 0, 0, 0, "rereset");
    // hold limit rotation 0 -> 1 -> 2 -> wrap 0
    repeat (3) drv(0, 0, 3'b111, 1, 3'b001, 0, 1, 0, "hold_m0");
    repeat (4) drv(0, 0, 3'b111, 1, 3'b010, 1, 1, 0, "hold_m1");
    repeat (4) drv(0, 0, 3'b111, 1, 3'b100, 2, 1, 0, "hold_m2");
    drv(0, 0, 3'b111, 1, 3'b001, 0, 1, 0, "hold_wrap");
    // ready gating: idle cycles do not advance the hold count
    drv(0, 0, 3'b011, 1, 3'b001, 0, 1, 0, "gate_r1");
    repeat (2) drv(0, 0, 3'b011, 0, 3'b001, 0, 1, 0, "gate_r0");
    repeat (2) drv(0, 0, 3'b011, 1, 3'b001, 0, 1, 0, "gate_r1b");
    drv(0, 0, 3'b011, 0, 3'b001, 0, 1, 0, "gate_r0b");
    drv(0, 0, 3'b011, 1, 3'b010, 1, 1, 0, "gate_rot");
    drv(0, 0, 3'b001, 0, 3'b010, 1, 1, 0, "drop_unready");
    // master drops request on a ready cycle
    drv(0, 0, 3'b011, 1, 3'b010, 1, 1, 0, "drop_keep");
    drv(0, 0, 3'b001, 1, 3'b001, 0, 1, 0, "drop_rot");
    repeat (3) drv(0, 0, 3'b011, 1, 3'b001, 0, 1, 0, "drop_holdclr");
    drv(0, 0, 3'b011, 1, 3'b010, 1, 1, 0, "drop_after");
    // park, then idle bus picks up a new requester
    drv(0, 0, 3'b000, 1, 3'b010, 1, 0, 0, "park");
    drv(0, 0, 3'b100, 1, 3'b100, 2, 1, 0, "unpark");
    // starvation with STARVE_LIM=2, reset mid-burst
    drv(1, 1, 3'b000, 1, 3'b001, 0, 0, 0, "sv_reset");
    drv(1, 0, 3'b011, 1, 3'b001, 0, 1, 0, "sv_w1");
    drv(1, 0, 3'b011, 1, 3'b001, 0, 1, 1, "sv_w2");
    drv(1, 1, 3'b011, 1, 3'b001, 0, 0, 0, "sv_midrst");
    drv(1, 0, 3'b011, 1, 3'b001, 0, 1, 0, "sv_post1");
    drv(1, 0, 3'b011, 1, 3'b001, 0, 1, 1, "sv_post2");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
